// File: rtl/pulse_sched_gen_if.sv
// pulse_sched_gen_if: run controls, schedule-table write port and pulse outputs of pulse_sched_gen.
// master drives controls and table writes; slave is the generator.
interface pulse_sched_gen_if #(
  parameter int DIV_W     = 32,
  parameter int SEQ_DEPTH = 16,
  parameter int SECS_W    = 8
);
  localparam int AW = $clog2(SEQ_DEPTH);

  logic              start;
  logic [1:0]        mode;
  logic              seq_we;
  logic [AW-1:0]     seq_addr;
  logic [DIV_W-1:0]  seq_half;
  logic [SECS_W-1:0] seq_secs;
  logic [AW:0]       seq_len;
  logic              pulse_out;
  logic              step;
  logic [15:0]       step_count;
  logic [AW-1:0]     seq_idx;
  logic              seq_done;
  logic              pulse1;
  logic              pulsehalf;

  modport master (
    output start, mode, seq_we, seq_addr, seq_half, seq_secs, seq_len,
    input  pulse_out, step, step_count, seq_idx, seq_done, pulse1, pulsehalf
  );

  modport slave (
    input  start, mode, seq_we, seq_addr, seq_half, seq_secs, seq_len,
    output pulse_out, step, step_count, seq_idx, seq_done, pulse1, pulsehalf
  );
endinterface

// File: rtl/pulse_sched_gen.sv
// pulse_sched_gen: 50%-duty step pulse at a fixed rate or from a (half-period, seconds) schedule table,
// plus free-running 1 Hz / 0.5 Hz references. Define SEQ_LOOP_EN to repeat the schedule instead of stopping.
module pulse_sched_gen #(
  parameter int CLK_HZ    = 100000000,
  parameter int DIV_W     = 32,
  parameter int SEQ_DEPTH = 16,
  parameter int SECS_W    = 8,
  parameter int RATE_A    = 32,
  parameter int RATE_B    = 64,
  parameter int RATE_C    = 128
) (
  input  logic             clk,
  input  logic             rst,
  pulse_sched_gen_if.slave bus
);
  // state      | meaning
  // S_IDLE     | start low, pulse quiet, counters held
  // S_FIXED    | fixed-rate square wave selected by mode 00/01/10
  // S_SEQ_LOAD | one cycle: latch table[seq_idx], skip zero-second entries
  // S_SEQ_RUN  | square wave at latched half-period for latched seconds
  // S_DONE     | schedule finished, seq_done held until start falls or mode changes
  typedef enum logic [2:0] {S_IDLE, S_FIXED, S_SEQ_LOAD, S_SEQ_RUN, S_DONE} state_t;

  localparam int AW = $clog2(SEQ_DEPTH);
  localparam logic [DIV_W-1:0] HALF_A   = DIV_W'(CLK_HZ / (2 * RATE_A));
  localparam logic [DIV_W-1:0] HALF_B   = DIV_W'(CLK_HZ / (2 * RATE_B));
  localparam logic [DIV_W-1:0] HALF_C   = DIV_W'(CLK_HZ / (2 * RATE_C));
  localparam logic [31:0]      SEC_LAST = 32'(CLK_HZ - 1);
  localparam logic [31:0]      P1_LAST  = 32'(CLK_HZ / 2 - 1);
  localparam logic [AW:0]      LEN_MAX  = (AW+1)'(SEQ_DEPTH);

  state_t            state;
  logic [DIV_W-1:0]  tbl_half [SEQ_DEPTH];
  logic [SECS_W-1:0] tbl_secs [SEQ_DEPTH];
  logic [DIV_W-1:0]  div_cnt, run_half, fixed_half, act_half;
  logic [31:0]       sec_cnt, p1_cnt;
  logic [SECS_W-1:0] secs_left;
  logic [AW:0]       len_last;
  logic [1:0]        mode_q;
  logic              start_q, restart, run_end, do_adv, idx_last;
  logic              pulse_q, step_q, done_q, p1_q, ph_q;
  logic [15:0]       step_cnt_q;
  logic [AW-1:0]     idx_q;

  always_ff @(posedge clk) begin
    if (bus.seq_we) begin
      tbl_half[bus.seq_addr] <= bus.seq_half;
      tbl_secs[bus.seq_addr] <= bus.seq_secs;
    end
  end

  always_comb begin
    case (bus.mode)
      2'b01:   fixed_half = HALF_B;
      2'b10:   fixed_half = HALF_C;
      default: fixed_half = HALF_A;
    endcase
  end

  always_comb begin
    if (bus.seq_len == '0)          len_last = '0;
    else if (bus.seq_len > LEN_MAX) len_last = LEN_MAX - (AW+1)'(1);
    else                            len_last = bus.seq_len - (AW+1)'(1);
  end

  assign act_half = (state == S_FIXED) ? fixed_half : run_half;
  assign idx_last = ({1'b0, idx_q} >= len_last);
  assign restart  = bus.start && (!start_q || (bus.mode != mode_q));
  assign run_end  = (state == S_SEQ_RUN) && (sec_cnt == '0) && (secs_left <= SECS_W'(1));
  assign do_adv   = run_end || ((state == S_SEQ_LOAD) && (tbl_secs[idx_q] == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      mode_q     <= 2'b00;
      div_cnt    <= '0;
      run_half   <= '0;
      sec_cnt    <= '0;
      secs_left  <= '0;
      pulse_q    <= 1'b0;
      step_q     <= 1'b0;
      step_cnt_q <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      start_q <= bus.start;
      mode_q  <= bus.mode;
      step_q  <= 1'b0;
      if (!bus.start) begin
        state     <= S_IDLE;
        pulse_q   <= 1'b0;
        done_q    <= 1'b0;
        div_cnt   <= '0;
        sec_cnt   <= '0;
        secs_left <= '0;
      end else if (restart) begin
        pulse_q    <= 1'b0;
        done_q     <= 1'b0;
        step_cnt_q <= '0;
        idx_q      <= '0;
        sec_cnt    <= '0;
        secs_left  <= '0;
        if (bus.mode == 2'b11) begin
          state   <= S_SEQ_LOAD;
          div_cnt <= '0;
        end else begin
          state   <= S_FIXED;
          div_cnt <= fixed_half - DIV_W'(1);
        end
      end else begin
        done_q <= 1'b0;
        case (state)
          S_SEQ_LOAD: begin
            run_half  <= tbl_half[idx_q];
            secs_left <= tbl_secs[idx_q];
            sec_cnt   <= SEC_LAST;
            div_cnt   <= tbl_half[idx_q] - DIV_W'(1);
            pulse_q   <= 1'b0;
            state     <= S_SEQ_RUN;
          end
          S_FIXED, S_SEQ_RUN: begin
            if (state == S_SEQ_RUN) begin
              if (sec_cnt == '0) begin
                sec_cnt   <= SEC_LAST;
                secs_left <= secs_left - SECS_W'(1);
              end else begin
                sec_cnt <= sec_cnt - 32'd1;
              end
            end
            // entry end overrides any divider toggle on the same edge
            if (run_end) begin
              pulse_q <= 1'b0;
              div_cnt <= '0;
            end else if (act_half == '0) begin
              pulse_q <= 1'b0;
            end else if (div_cnt == '0) begin
              div_cnt <= act_half - DIV_W'(1);
              pulse_q <= !pulse_q;
              if (!pulse_q) begin
                step_q     <= 1'b1;
                step_cnt_q <= step_cnt_q + 16'd1;
              end
            end else begin
              div_cnt <= div_cnt - DIV_W'(1);
            end
          end
          S_DONE:  done_q <= 1'b1;
          default: ;
        endcase
        if (do_adv) begin
          if (!idx_last) begin
            idx_q <= idx_q + AW'(1);
            state <= S_SEQ_LOAD;
          end else begin
`ifdef SEQ_LOOP_EN
            idx_q <= '0;
            state <= S_SEQ_LOAD;
`else
            state <= S_DONE;
`endif
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  // pulsehalf toggles on each pulse1 fall, giving half the pulse1 rate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_cnt <= P1_LAST;
      p1_q   <= 1'b0;
      ph_q   <= 1'b0;
    end else if (p1_cnt == '0) begin
      p1_cnt <= P1_LAST;
      p1_q   <= !p1_q;
      if (p1_q) ph_q <= !ph_q;
    end else begin
      p1_cnt <= p1_cnt - 32'd1;
    end
  end

  assign bus.pulse_out  = pulse_q;
  assign bus.step       = step_q;
  assign bus.step_count = step_cnt_q;
  assign bus.seq_idx    = idx_q;
  assign bus.seq_done   = done_q;
  assign bus.pulse1     = p1_q;
  assign bus.pulsehalf  = ph_q;
endmodule

// File: tb/tb_pulse_sched_gen.sv
// tb_pulse_sched_gen: directed checks of pulse_sched_gen at CLK_HZ=6400 (fixed halves 100/50/25).
// All stimulus is driven and all outputs sampled 1 time unit after the rising clock edge.
module tb_pulse_sched_gen;
  localparam int CLK_HZ    = 6400;
  localparam int DIV_W     = 32;
  localparam int SEQ_DEPTH = 16;
  localparam int SECS_W    = 8;
  localparam int AW        = $clog2(SEQ_DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pulse_sched_gen_if #(.DIV_W(DIV_W), .SEQ_DEPTH(SEQ_DEPTH), .SECS_W(SECS_W)) bus ();

  pulse_sched_gen #(
    .CLK_HZ(CLK_HZ), .DIV_W(DIV_W), .SEQ_DEPTH(SEQ_DEPTH), .SECS_W(SECS_W),
    .RATE_A(32), .RATE_B(64), .RATE_C(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int half, input int secs);
    bus.seq_we   = 1'b1;
    bus.seq_addr = AW'(a);
    bus.seq_half = DIV_W'(half);
    bus.seq_secs = SECS_W'(secs);
    cyc(1);
    bus.seq_we   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.mode = 2'b00; bus.seq_we = 1'b0; bus.seq_addr = '0;
    bus.seq_half = '0; bus.seq_secs = '0; bus.seq_len = 5'd3;
    cyc(2);
    chk("rst_pulse_out", bus.pulse_out, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_step_count", bus.step_count, 0);
    chk("rst_seq_idx", bus.seq_idx, 0);
    chk("rst_seq_done", bus.seq_done, 0);
    chk("rst_pulse1", bus.pulse1, 0);
    chk("rst_pulsehalf", bus.pulsehalf, 0);
    wr(0, 10, 1); wr(1, 0, 1); wr(2, 20, 2);
    rst = 1'b0;

    // references: pulse1 toggles every 3200 cycles, pulsehalf on pulse1 falls
    cyc(3199); chk("p1_before", bus.pulse1, 0);
    cyc(1);    chk("p1_rise", bus.pulse1, 1);
    chk("idle_pulse_out", bus.pulse_out, 0);
    cyc(3199); chk("ph_before", bus.pulsehalf, 0);
    cyc(1);    chk("p1_fall", bus.pulse1, 0);
    chk("ph_rise", bus.pulsehalf, 1);

    // fixed mode 00: half 100
    bus.mode = 2'b00; bus.start = 1'b1;
    cyc(100); chk("fixa_pre", bus.pulse_out, 0);
    cyc(1);   chk("fixa_rise", bus.pulse_out, 1);
    chk("fixa_step", bus.step, 1);
    chk("fixa_cnt1", bus.step_count, 1);
    cyc(1);   chk("fixa_step_off", bus.step, 0);
    cyc(99);  chk("fixa_fall", bus.pulse_out, 0);
    cyc(100); chk("fixa_rise2", bus.pulse_out, 1);
    chk("fixa_cnt2", bus.step_count, 2);

    // mode change 00 -> 01 (half 50) -> 10 (half 25)
    bus.mode = 2'b01;
    cyc(50); chk("fixb_pre", bus.pulse_out, 0);
    chk("fixb_cnt0", bus.step_count, 0);
    cyc(1);  chk("fixb_rise", bus.pulse_out, 1);
    bus.mode = 2'b10;
    cyc(1);  chk("fixc_clr_cnt", bus.step_count, 0);
    chk("fixc_clr_pulse", bus.pulse_out, 0);
    cyc(24); chk("fixc_pre", bus.pulse_out, 0);
    cyc(1);  chk("fixc_rise", bus.pulse_out, 1);
    cyc(49); chk("fixc_low", bus.pulse_out, 0);
    cyc(1);  chk("fixc_rise2", bus.pulse_out, 1);
    chk("fixc_cnt2", bus.step_count, 2);
    bus.start = 1'b0;
    cyc(1);  chk("fix_stop_pulse", bus.pulse_out, 0);
    chk("fix_stop_cnt", bus.step_count, 2);

    // schedule {(10,1),(0,1),(20,2)}
    bus.mode = 2'b11; bus.start = 1'b1;
    cyc(1);     chk("sch_idx0", bus.seq_idx, 0);
    chk("sch_cnt0", bus.step_count, 0);
    cyc(10);    chk("sch_pre", bus.pulse_out, 0);
    cyc(1);     chk("sch_rise", bus.pulse_out, 1);
    chk("sch_step", bus.step, 1);
    cyc(6389);  chk("sch_e0_cnt", bus.step_count, 320);
    chk("sch_e0_idx", bus.seq_idx, 0);
    cyc(1);     chk("sch_e0_end_pulse", bus.pulse_out, 0);
    chk("sch_e1_idx", bus.seq_idx, 1);
    cyc(2600);  chk("sch_silent_pulse", bus.pulse_out, 0);
    chk("sch_silent_cnt", bus.step_count, 320);
    cyc(3821);  chk("sch_e2_pre", bus.pulse_out, 0);
    chk("sch_e2_idx", bus.seq_idx, 2);
    cyc(1);     chk("sch_e2_rise", bus.pulse_out, 1);
    chk("sch_e2_cnt", bus.step_count, 321);
    cyc(12779); chk("sch_total", bus.step_count, 640);
    chk("sch_done_pre", bus.seq_done, 0);
    cyc(1);     chk("sch_done", bus.seq_done, 1);
    chk("sch_done_pulse", bus.pulse_out, 0);
`ifdef SEQ_LOOP_EN
    chk("loop_idx_wrap", bus.seq_idx, 0);
    cyc(1);     chk("loop_done_pulse_off", bus.seq_done, 0);
`else
    chk("done_idx", bus.seq_idx, 2);
    cyc(5);     chk("done_hold", bus.seq_done, 1);
    chk("done_hold_pulse", bus.pulse_out, 0);
`endif
    bus.start = 1'b0;
    cyc(1);     chk("stop_done_clr", bus.seq_done, 0);

    // skip entry: {(10,1),(7,0),(5,1)}
    wr(1, 7, 0); wr(2, 5, 1);
    bus.start = 1'b1;
    cyc(1);    chk("skip_cnt_clr", bus.step_count, 0);
    chk("skip_idx0", bus.seq_idx, 0);
    cyc(6400); chk("skip_e0_cnt", bus.step_count, 320);
    cyc(1);    chk("skip_idx1", bus.seq_idx, 1);
    cyc(1);    chk("skip_idx2", bus.seq_idx, 2);
    cyc(5);    chk("skip_e2_pre", bus.pulse_out, 0);
    cyc(1);    chk("skip_e2_rise", bus.pulse_out, 1);
    chk("skip_e2_cnt", bus.step_count, 321);

    // start falls mid-entry, then restarts
    bus.start = 1'b0;
    cyc(1);    chk("midstop_pulse", bus.pulse_out, 0);
    bus.start = 1'b1;
    cyc(1);    chk("restart_idx", bus.seq_idx, 0);
    chk("restart_cnt", bus.step_count, 0);
    cyc(10);   chk("restart_pre", bus.pulse_out, 0);
    cyc(1);    chk("restart_rise", bus.pulse_out, 1);

    // asynchronous reset mid-run; table must survive
    #2 rst = 1'b1;
    #1 chk("arst_pulse", bus.pulse_out, 0);
    chk("arst_step", bus.step, 0);
    chk("arst_cnt", bus.step_count, 0);
    cyc(1);
    rst = 1'b0;
    cyc(11);   chk("tbl_keep_pre", bus.pulse_out, 0);
    cyc(1);    chk("tbl_keep_rise", bus.pulse_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
